// File: rtl/afpm_pkg.sv
// Shared definitions for the logarithmic (Mitchell) FP16 multiplier:
// field widths, log-domain constants and the serial frame slot states.
package afpm_pkg;

  localparam int EXP_W = 5;
  localparam int MAN_W = 10;

  // Exponent bias (15) aligned to bit 10, removed from the log-domain sum
  localparam logic [15:0] BIAS_LOG = 16'h3C00;
  localparam logic [15:0] QNAN     = 16'h7E00;
  localparam logic [14:0] INF_MAG  = 15'h7C00;
  // Constant Mitchell error compensation used when LOG_CORR_EN is defined
  localparam logic [15:0] CORR_K   = 16'h0040;

  // Clock cycles spent in each serial slot
  localparam int SLOT_CYCLES = 2;

  typedef enum logic [2:0] {
    IN_LO  = 3'd0,
    IN_HI  = 3'd1,
    CALC   = 3'd2,
    OUT_LO = 3'd3,
    OUT_HI = 3'd4
  } slot_e;

endpackage

// File: rtl/afpm_log_mul.sv
// Combinational FP16 multiply by Mitchell's logarithmic approximation:
// the biased exponent/mantissa fields are added as one fixed-point log value.
// Optional macro LOG_CORR_EN adds a constant error-compensation term to the sum.
module afpm_log_mul
  import afpm_pkg::*;
(
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  output logic [15:0] r_o
);

  // Largest sum whose unbiased exponent is still <= 0 (underflow region)
  localparam logic [15:0] UFLOW_MAX = BIAS_LOG + 16'h03FF;
  localparam logic [15:0] OFLOW_MIN = {1'b0, INF_MAG};

  logic             sign;
  logic [EXP_W-1:0] expA, expB;
  logic [MAN_W-1:0] manA, manB;
  logic             aNan, bNan, aInf, bInf, aZero, bZero;
  logic [15:0]      logSum;
  logic [15:0]      unbiased;

  assign sign  = a_i[15] ^ b_i[15];
  assign expA  = a_i[14:10];
  assign expB  = b_i[14:10];
  assign manA  = a_i[9:0];
  assign manB  = b_i[9:0];
  assign aNan  = (expA == '1) && (manA != '0);
  assign bNan  = (expB == '1) && (manB != '0);
  assign aInf  = (expA == '1) && (manA == '0);
  assign bInf  = (expB == '1) && (manB == '0);
  // Subnormals are flushed, so any zero exponent counts as zero
  assign aZero = (expA == '0);
  assign bZero = (expB == '0);

`ifdef LOG_CORR_EN
  assign logSum = {1'b0, a_i[14:0]} + {1'b0, b_i[14:0]} + CORR_K;
`else
  assign logSum = {1'b0, a_i[14:0]} + {1'b0, b_i[14:0]};
`endif

  assign unbiased = logSum - BIAS_LOG;

  // Special cases take priority, then range-check the log-domain sum
  always_comb begin
    r_o = {sign, unbiased[14:0]};
    if (aNan || bNan || (aInf && bZero) || (bInf && aZero)) begin
      r_o = QNAN;
    end else if (aInf || bInf) begin
      r_o = {sign, INF_MAG};
    end else if (aZero || bZero) begin
      r_o = {sign, 15'h0000};
    end else if (logSum <= UFLOW_MAX) begin
      r_o = {sign, 15'h0000};
    end else if (unbiased >= OFLOW_MIN) begin
      r_o = {sign, INF_MAG};
    end
  end

endmodule

// File: rtl/logarithmic_afpm.sv
// Tiny Tapeout wrapper for the Mitchell FP16 multiplier. Operands arrive
// low byte first on ui_in/uio_in, the product leaves on uo_out, all on a
// fixed free-running 5-slot frame with no handshake.
// Optional macro LOG_CORR_EN enables error compensation in afpm_log_mul.
module logarithmic_afpm
  import afpm_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int SUB_W = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(SLOT_CYCLES - 1);

  slot_e            slotQ, slotD;
  logic [SUB_W-1:0] subQ, subD;
  logic [15:0]      opAQ, opAD;
  logic [15:0]      opBQ, opBD;
  logic [15:0]      resQ, resD;
  logic [7:0]       uoQ, uoD;
  logic [15:0]      product;
  logic             lastCycle;
  logic             unusedEna;

  assign unusedEna = ena;
  assign uio_out   = 8'h00;
  assign uio_oe    = 8'h00;
  assign uo_out    = uoQ;

  afpm_log_mul uMul (
    .a_i (opAQ),
    .b_i (opBQ),
    .r_o (product)
  );

  assign lastCycle = (subQ == SUB_LAST);

  // Slot sequencing, operand capture, result latch and output byte select
  always_comb begin
    slotD = slotQ;
    subD  = subQ + 1'b1;
    opAD  = opAQ;
    opBD  = opBQ;
    resD  = resQ;
    uoD   = uoQ;

    if (lastCycle) begin
      subD = '0;
      case (slotQ)
        IN_LO:   slotD = IN_HI;
        IN_HI:   slotD = CALC;
        CALC:    slotD = OUT_LO;
        OUT_LO:  slotD = OUT_HI;
        default: slotD = IN_LO;
      endcase
    end

    case (slotQ)
      IN_LO: begin
        if (lastCycle) begin
          opAD[7:0] = ui_in;
          opBD[7:0] = uio_in;
        end
      end
      IN_HI: begin
        if (lastCycle) begin
          opAD[15:8] = ui_in;
          opBD[15:8] = uio_in;
        end
      end
      CALC: begin
        if (subQ == '0) begin
          resD = product;
        end
      end
      default: ;
    endcase

    // The output register only moves on the edge that enters a new slot
    if (lastCycle) begin
      case (slotD)
        OUT_LO:  uoD = resD[7:0];
        OUT_HI:  uoD = resD[15:8];
        default: uoD = 8'h00;
      endcase
    end
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      slotQ <= IN_LO;
      subQ  <= '0;
      opAQ  <= '0;
      opBQ  <= '0;
      resQ  <= '0;
      uoQ   <= '0;
    end else begin
      slotQ <= slotD;
      subQ  <= subD;
      opAQ  <= opAD;
      opBQ  <= opBD;
      resQ  <= resD;
      uoQ   <= uoD;
    end
  end

endmodule

// File: tb/tb_logarithmic_afpm.sv
// Scoreboard bench for logarithmic_afpm: stimulus pushes the hand-computed
// product for each frame, a negedge monitor tracks frame position and
// compares uo_out in the output slots (zero elsewhere and during reset).
module tb_logarithmic_afpm;

`ifdef LOG_CORR_EN
  localparam bit CORR = 1'b1;
`else
  localparam bit CORR = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int testsRun    = 0;
  int testsFailed = 0;

  logic [15:0] expQ[$];
  int          frameCyc = 0;
  bit          inReset  = 1'b0;
  bit          started  = 1'b0;

  logarithmic_afpm dut (
    .clk     (clk),
    .rst     (rst),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [15:0] actual,
                             input logic [15:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, actual, expected);
    end
  endtask

  // Model of the frame position the DUT holds after each edge
  always @(posedge clk) begin
    if (rst) begin
      frameCyc <= 0;
      started  <= 1'b1;
    end else begin
      frameCyc <= (frameCyc == 9) ? 0 : frameCyc + 1;
    end
    inReset <= rst;
  end

  // Monitor: compare uo_out against the scoreboard in the output slots
  always @(negedge clk) begin
    logic [15:0] front;
    if (started) begin
      front = (expQ.size() > 0) ? expQ[0] : 16'h0000;
      checkOutput("uio_oe", {8'h00, uio_oe}, 16'h0000);
      checkOutput("uio_out", {8'h00, uio_out}, 16'h0000);
      if (inReset) begin
        checkOutput("uo_reset", {8'h00, uo_out}, 16'h0000);
      end else begin
        case (frameCyc)
          6, 7: checkOutput("uo_lo", {8'h00, uo_out}, {8'h00, front[7:0]});
          8:    checkOutput("uo_hi", {8'h00, uo_out}, {8'h00, front[15:8]});
          9: begin
            checkOutput("uo_hi", {8'h00, uo_out}, {8'h00, front[15:8]});
            if (expQ.size() > 0) void'(expQ.pop_front());
          end
          default: checkOutput("uo_idle", {8'h00, uo_out}, 16'h0000);
        endcase
      end
    end
  end

  // One full frame starting at frame cycle 0; the first cycle of each input
  // slot carries filler so capture on the wrong cycle shows up
  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b,
                               input logic [15:0] expected);
    expQ.push_back(expected);
    for (int c = 0; c < 10; c++) begin
      case (c)
        1:       begin ui_in = a[7:0];  uio_in = b[7:0];  end
        3:       begin ui_in = a[15:8]; uio_in = b[15:8]; end
        default: begin ui_in = 8'hA5;   uio_in = 8'h5A;   end
      endcase
      @(posedge clk);
      #1;
    end
  endtask

  // Partial frame cut off by reset during the high-byte slot
  task automatic abortFrame();
    ui_in = 8'h11; uio_in = 8'h22;
    repeat (3) begin @(posedge clk); #1; end
    ui_in = 8'h33; uio_in = 8'h44;
    rst = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b0;
  endtask

  initial begin
    #50000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1; ena = 1'b1; ui_in = 8'h00; uio_in = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    applyStimulus(16'h3E00, 16'h4200, CORR ? 16'h4440 : 16'h4400);
    applyStimulus(16'h3C00, 16'hC500, CORR ? 16'hC540 : 16'hC500);
    applyStimulus(16'h0000, 16'h7C00, 16'h7E00);
    applyStimulus(16'h8000, 16'h4000, 16'h8000);
    applyStimulus(16'h7800, 16'h7800, 16'h7C00);
    applyStimulus(16'h0400, 16'h0400, 16'h0000);
    applyStimulus(16'hC000, 16'hC200, CORR ? 16'h4640 : 16'h4600);
    applyStimulus(16'h2000, 16'h2000, CORR ? 16'h0440 : 16'h0400);
    applyStimulus(16'h2000, 16'h1FFF, CORR ? 16'h043F : 16'h0000);
    applyStimulus(16'h5C00, 16'h5BFF, CORR ? 16'h7C00 : 16'h7BFF);
    applyStimulus(16'h7C01, 16'h3C00, 16'h7E00);
    applyStimulus(16'h7C00, 16'hBC00, 16'hFC00);
    applyStimulus(16'h0001, 16'h3C00, 16'h0000);

    abortFrame();
    applyStimulus(16'h4000, 16'h4000, CORR ? 16'h4440 : 16'h4400);
    applyStimulus(16'h4100, 16'h4100, CORR ? 16'h4640 : 16'h4600);

    repeat (2) @(posedge clk);
    #1;
    checkOutput("queue_drained", 16'(expQ.size()), 16'h0000);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/logarithmic_afpm.md
Name: logarithmic_afpm

Overview:
- Approximate FP16 (IEEE binary16) multiplier using Mitchell's logarithmic approximation.
- Tiny Tapeout user block. Operand A arrives byte-serially on ui_in and operand B on uio_in, low byte first. The 16-bit product leaves byte-serially on uo_out.
- Free-running, fixed-schedule frame; no valid/ready handshake.

Parameters:
- BIAS_LOG, 16'h3C00, FP16 exponent bias (15) aligned to bit 10; subtracted from the log-domain sum.
- SLOT_CYCLES, 2, clock cycles per serial slot.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- ena  in  1  tile-select; ignored by the logic (unused).
- ui_in  in  8  operand A byte stream.
- uio_in  in  8  operand B byte stream.
- uo_out  out  8  product byte stream (registered).
- uio_out  out  8  constant 8'h00.
- uio_oe  out  8  constant 8'h00 (uio is input-only).

Behaviour:
- Frame FSM, slot counter 0..4. Each slot lasts SLOT_CYCLES cycles; slot k covers frame cycles 2k and 2k+1. After slot 4 the FSM wraps to slot 0, giving a 10-cycle frame.
- Slot 0 (IN_LO): on the last cycle of the slot, A[7:0]<=ui_in and B[7:0]<=uio_in.
- Slot 1 (IN_HI): on the last cycle of the slot, A[15:8]<=ui_in and B[15:8]<=uio_in.
- Slot 2 (CALC): on the first cycle of the slot, R<=f(A,B).
- Slot 3 (OUT_LO): uo_out=R[7:0].
- Slot 4 (OUT_HI): uo_out=R[15:8].
- In slots 0-2, uo_out=8'h00. uo_out is registered and changes on the first edge of each slot.
- Reset: while rst=1 at a clock edge, FSM goes to slot 0 cycle 0 and A, B, R, uo_out are all cleared to 0.
  - The first cycle after rst falls is frame cycle 0.
  - Reset mid-frame discards partial operands and any pending result.
- f(A,B) definitions: s=A[15]^B[15]; LA=A[14:0]; LB=B[14:0]; eA=A[14:10]; eB=B[14:10].
- f(A,B) rules, in priority order:
  1. NaN operand (e=31, mant!=0), or inf times zero: R=16'h7E00.
  2. Either operand inf (e=31): R={s,15'h7C00}.
  3. Either operand zero or subnormal (e=0; subnormals flushed): R={s,15'h0}.
  4. Otherwise compute S=LA+LB as 16 bits unsigned (mantissa carry propagates into the exponent; this is the Mitchell approximation).
     - S<=BIAS_LOG+16'h03FF (result exponent <=0): R={s,15'h0} (underflow, flush).
     - S-BIAS_LOG>=16'h7C00: R={s,15'h7C00} (overflow to inf).
     - Else R={s,(S-BIAS_LOG)[14:0]}.
- Mantissa is truncated; no rounding.

Optional Feature:
- LOG_CORR_EN: when defined, rule 4 uses S=LA+LB+16'h0040, a constant Mitchell error compensation of +1/16 mantissa LSB-aligned. Underflow and overflow checks apply to the corrected S.
- Without it: pure Mitchell sum, as above.
- Special cases (rules 1-3) are unaffected either way.

Decomposition:
- Shared package afpm_pkg holds:
  - FP16 field widths (EXP_W=5, MAN_W=10).
  - Constants BIAS_LOG, QNAN=16'h7E00, INF_MAG=15'h7C00, CORR_K=16'h0040.
  - Slot-state enum {IN_LO, IN_HI, CALC, OUT_LO, OUT_HI}.
- One combinational sub-module, afpm_log_mul: f(A,B) including special cases and the LOG_CORR_EN path.
- Top level holds the FSM, operand/result registers and the I/O muxing.

Test Plan:
- A=16'h3E00 (1.5), B=16'h4200 (3.0), low bytes 00/00 then high bytes 3E/42 -> R=16'h4400 (4.0); uo_out=8'h00 in OUT_LO, 8'h44 in OUT_HI. With LOG_CORR_EN: 8'h40 then 8'h44 (R=16'h4440).
- A=16'h3C00 (1.0), B=16'hC500 (-5.0) -> R=16'hC500 (exact when one mantissa is 0).
- A=16'h0000, B=16'h7C00 -> R=16'h7E00 (NaN); A=16'h8000, B=16'h4000 -> R=16'h8000.
- A=16'h7800, B=16'h7800 (32768*32768) -> R=16'h7C00 overflow; A=16'h0400, B=16'h0400 -> R=16'h0000 underflow.
- Assert rst during IN_HI, then run a fresh frame with A=16'h4000, B=16'h4000 -> uo_out=0 during reset; then R=16'h4400 reported in the next frame's OUT slots only.
- Back-to-back frames with different operands -> each result appears exactly in slots 3-4 of its own frame; uio_oe and uio_out are 0 at all times.
